neuron_prog_ctrl: RTL and testbench
===================================

Name: neuron_prog_ctrl

Overview:
Front-end sequencer for the neuron array. It parses the 16-bit host input word stream into per-neuron configuration writes (Vmem, mu, neuron ID, Q row), then runs the anneal phase, broadcasting global mu words. It sits between the chip input pins (ins, valid) and the neuron array write and broadcast buses. It also asserts run and done status for the spin readout logic.

Parameters:
FP_DATA_WIDTH, 16, width of input words, Vmem, mu and Q data
NUM_NEURON, 512, number of physical neurons; neuron IDs must be below this
NEURON_ID_WIDTH, 9, width of neuron ID fields
MAX_ACTIVE, 10, maximum number of active neurons, which is also the length of each Q row
Q_ADDR_WIDTH, 4, Q RAM address width; must satisfy 2^Q_ADDR_WIDTH >= MAX_ACTIVE
NUM_MU_STEPS, 166, number of mu words in the anneal schedule

Ports:
clk  in  1  single clock; all state changes on the rising edge
reset_l  in  1  synchronous active-low reset, sampled on the clk rising edge
ins  in  FP_DATA_WIDTH  input word
ins_valid  in  1  ins carries a word this cycle
ins_ready  out  1  controller can accept a word; a word transfers when ins_valid and ins_ready are both high
cfg_wr_en  out  1  one-cycle pulse: write Vmem and mu to neuron cfg_id
cfg_id  out  NEURON_ID_WIDTH  target neuron for configuration and Q writes
cfg_vmem  out  FP_DATA_WIDTH  Vmem value to write
cfg_mu  out  FP_DATA_WIDTH  initial mu value to write
q_wr_en  out  1  one-cycle pulse: write q_data into Q RAM of neuron cfg_id at address q_addr
q_addr  out  Q_ADDR_WIDTH  Q RAM address
q_data  out  FP_DATA_WIDTH  Q word
mu_bcast_valid  out  1  one-cycle pulse: global mu update
mu_bcast_data  out  FP_DATA_WIDTH  global mu value
run  out  1  high during the anneal phase (neuron firing enabled)
done  out  1  high after the last mu step; held until reset
err  out  1  protocol error; held until reset

Behaviour:
- Reset: state=IDLE. All outputs are 0 except ins_ready=1. All counters are cleared. Reset mid-stream aborts the operation, and no write pulse is emitted in the cycle after reset.
- Latency: every output pulse occurs in the cycle after the transfer that causes it. All outputs are registered.
- The controller applies no backpressure: ins_ready=1 in every state except DONE and ERR, where it is 0.
- The controller counts only transfers. Cycles with ins_valid=0 do not advance the state.
- IDLE: the transfer word is n_active. If n_active is 0 or greater than MAX_ACTIVE, go to ERR. Otherwise latch n_active and go to SYNC.
- SYNC: the word must be 0xFFFF. If it is, set nrem=n_active and go to VMEM. Any other value goes to ERR.
- VMEM: latch the word into the Vmem buffer, then go to MU.
- MU: latch the word into the mu buffer, then go to NID.
- NID: the ID is ins[NEURON_ID_WIDTH-1:0].
  - If the upper bits are nonzero or the ID is NUM_NEURON or above, go to ERR.
  - Otherwise latch cfg_id, emit one cfg_wr_en pulse with the buffered cfg_vmem and cfg_mu, clear qcnt, and go to QW.
- QW: each transfer emits q_wr_en with q_addr=qcnt and q_data=ins, then increments qcnt.
  - After the n_active-th Q word, decrement nrem.
  - If nrem reaches 0, go to RUN with run=1 in the next cycle. Otherwise go to VMEM.
- Duplicate neuron IDs are not checked; the last write wins.
- RUN: each transfer emits mu_bcast_valid with mu_bcast_data=ins and increments scnt. After transfer number NUM_MU_STEPS, go to DONE: run=0 and done=1 in the next cycle, together with the last broadcast pulse.
- ERR: err=1 and run=0. Only reset_l leaves ERR. Transfers in ERR produce no pulses.
- cfg_id, cfg_vmem, cfg_mu, q_addr and q_data hold their values between pulses. mu_bcast_data holds its last value.
- Counter widths: qcnt is Q_ADDR_WIDTH bits and never exceeds MAX_ACTIVE-1. nrem is $clog2(MAX_ACTIVE+1) bits. scnt is $clog2(NUM_MU_STEPS+1) bits and never wraps.

Test Plan:
- Reset then full load, n_active=2: stream 0x0002, 0xFFFF, 0x4400, 0x4300, 0x0000, 0x0001, 0x0002, 0x4500, 0x4540, 0x0005, 0x0000, 0x0003 -> expect:
  - cfg_wr_en for ID 0 with (0x4400, 0x4300).
  - q_wr_en at addr 0,1 with data 1,2.
  - cfg_wr_en for ID 5 with (0x4500, 0x4540).
  - q_wr_en at addr 0,1 with data 0,3.
  - run=1 one cycle after the last Q word.
- Bad sync: 0x0003, 0xFFFE -> err=1 the next cycle, ins_ready=0, and no writes for any later input.
- Bounds: n_active=0x000B -> err. Separately, n_active=1 with neuron ID 0x0200 -> err and no cfg_wr_en.
- Gapped valid: the same load as the first scenario with ins_valid low for 3 cycles between every word -> identical write sequence and data.
- Anneal: after the load, 166 mu words 0x3C00+i, with idle gaps of 6 cycles -> 166 mu_bcast_valid pulses carrying matching data; done=1 and run=0 after the 166th; a 167th word is not accepted (ins_ready=0).
- Reset mid-QW: assert reset_l=0 during the Q row of neuron 1 -> no pulses after reset; a fresh full load then succeeds.

Source files
------------

// File: rtl/neuron_prog_ctrl_if.sv
// neuron_prog_ctrl_if: host word stream plus neuron-array write/broadcast buses
interface neuron_prog_ctrl_if #(
    parameter int FP_DATA_WIDTH   = 16,
    parameter int NEURON_ID_WIDTH = 9,
    parameter int Q_ADDR_WIDTH    = 4
);
    logic [FP_DATA_WIDTH-1:0]   ins;
    logic                       ins_valid;
    logic                       ins_ready;
    logic                       cfg_wr_en;
    logic [NEURON_ID_WIDTH-1:0] cfg_id;
    logic [FP_DATA_WIDTH-1:0]   cfg_vmem;
    logic [FP_DATA_WIDTH-1:0]   cfg_mu;
    logic                       q_wr_en;
    logic [Q_ADDR_WIDTH-1:0]    q_addr;
    logic [FP_DATA_WIDTH-1:0]   q_data;
    logic                       mu_bcast_valid;
    logic [FP_DATA_WIDTH-1:0]   mu_bcast_data;
    logic                       run;
    logic                       done;
    logic                       err;

    modport master (
        output ins, ins_valid,
        input  ins_ready, cfg_wr_en, cfg_id, cfg_vmem, cfg_mu, q_wr_en, q_addr, q_data,
               mu_bcast_valid, mu_bcast_data, run, done, err
    );

    modport slave (
        input  ins, ins_valid,
        output ins_ready, cfg_wr_en, cfg_id, cfg_vmem, cfg_mu, q_wr_en, q_addr, q_data,
               mu_bcast_valid, mu_bcast_data, run, done, err
    );
endinterface

// File: rtl/neuron_prog_ctrl.sv
// neuron_prog_ctrl: parses the host word stream into neuron config/Q writes, then broadcasts the mu schedule
module neuron_prog_ctrl #(
    parameter int FP_DATA_WIDTH   = 16,
    parameter int NUM_NEURON      = 512,
    parameter int NEURON_ID_WIDTH = 9,
    parameter int MAX_ACTIVE      = 10,
    parameter int Q_ADDR_WIDTH    = 4,
    parameter int NUM_MU_STEPS    = 166
) (
    input logic              clk,
    input logic              reset_l,
    neuron_prog_ctrl_if.slave bus
);
    localparam int NW = $clog2(MAX_ACTIVE + 1);
    localparam int SW = $clog2(NUM_MU_STEPS + 1);

    typedef enum logic [3:0] {IDLE, SYNC, VMEM, MU, NID, QW, RUN, DONE, ERR} state_t;

    state_t                    state, state_d;
    logic [NW-1:0]             n_active, nrem;
    logic [Q_ADDR_WIDTH-1:0]   qcnt;
    logic [SW-1:0]             scnt;
    logic [FP_DATA_WIDTH-1:0]  vmem_buf, mu_buf;
    logic                      xfer, n_ok, id_ok, last_q;

    assign xfer   = bus.ins_valid && bus.ins_ready;
    assign n_ok   = bus.ins != '0 && bus.ins <= FP_DATA_WIDTH'(MAX_ACTIVE);
    assign id_ok  = bus.ins[FP_DATA_WIDTH-1:NEURON_ID_WIDTH] == '0 &&
                    {1'b0, bus.ins[NEURON_ID_WIDTH-1:0]} < (NEURON_ID_WIDTH + 1)'(NUM_NEURON);
    assign last_q = qcnt == Q_ADDR_WIDTH'(n_active - NW'(1));

    always_comb begin
        state_d = state;
        if (xfer)
            case (state)
                IDLE:    state_d = n_ok ? SYNC : ERR;
                SYNC:    state_d = &bus.ins ? VMEM : ERR;
                VMEM:    state_d = MU;
                MU:      state_d = NID;
                NID:     state_d = id_ok ? QW : ERR;
                QW:      state_d = !last_q ? QW : nrem == NW'(1) ? RUN : VMEM;
                RUN:     state_d = scnt == SW'(NUM_MU_STEPS - 1) ? DONE : RUN;
                default: state_d = state;
            endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            state              <= IDLE;
            n_active           <= '0;
            nrem               <= '0;
            qcnt               <= '0;
            scnt               <= '0;
            vmem_buf           <= '0;
            mu_buf             <= '0;
            bus.ins_ready      <= 1'b1;
            bus.cfg_wr_en      <= 1'b0;
            bus.cfg_id         <= '0;
            bus.cfg_vmem       <= '0;
            bus.cfg_mu         <= '0;
            bus.q_wr_en        <= 1'b0;
            bus.q_addr         <= '0;
            bus.q_data         <= '0;
            bus.mu_bcast_valid <= 1'b0;
            bus.mu_bcast_data  <= '0;
            bus.run            <= 1'b0;
            bus.done           <= 1'b0;
            bus.err            <= 1'b0;
        end else begin
            state              <= state_d;
            bus.ins_ready      <= !(state_d inside {DONE, ERR});
            bus.run            <= state_d == RUN;
            bus.done           <= state_d == DONE;
            bus.err            <= state_d == ERR;
            bus.cfg_wr_en      <= xfer && state == NID && id_ok;
            bus.q_wr_en        <= xfer && state == QW;
            bus.mu_bcast_valid <= xfer && state == RUN;
            if (xfer)
                case (state)
                    IDLE: n_active <= bus.ins[NW-1:0];
                    SYNC: nrem <= n_active;
                    VMEM: vmem_buf <= bus.ins;
                    MU:   mu_buf <= bus.ins;
                    NID: if (id_ok) begin
                        bus.cfg_id   <= bus.ins[NEURON_ID_WIDTH-1:0];
                        bus.cfg_vmem <= vmem_buf;
                        bus.cfg_mu   <= mu_buf;
                        qcnt         <= '0;
                    end
                    QW: begin
                        bus.q_addr <= qcnt;
                        bus.q_data <= bus.ins;
                        qcnt       <= last_q ? '0 : qcnt + 1'b1;
                        if (last_q) nrem <= nrem - NW'(1);
                    end
                    RUN: begin
                        bus.mu_bcast_data <= bus.ins;
                        scnt              <= scnt + 1'b1;
                    end
                    default: ;
                endcase
        end
    end
endmodule

// File: tb/tb_neuron_prog_ctrl.sv
// tb_neuron_prog_ctrl: scenario tasks checked against a stream-parsing reference model
module tb_neuron_prog_ctrl;
    logic clk = 1'b0;
    logic reset_l = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [63:0] got[$];
    bit   mon_en = 1'b1;

    neuron_prog_ctrl_if bus ();
    neuron_prog_ctrl dut (.clk(clk), .reset_l(reset_l), .bus(bus));

    always #5 clk = ~clk;

    // Events: kind 1 = cfg write, 2 = Q write, 3 = mu broadcast
    always @(negedge clk) if (mon_en) begin
        if (bus.cfg_wr_en) got.push_back({4'd1, 12'(bus.cfg_id), bus.cfg_vmem, bus.cfg_mu});
        if (bus.q_wr_en) got.push_back({4'd2, 12'(bus.q_addr), bus.q_data, 16'h0});
        if (bus.mu_bcast_valid) got.push_back({4'd3, 12'h0, bus.mu_bcast_data, 16'h0});
    end

    task automatic model(input logic [15:0] w[$], output logic [63:0] ev[$], output bit e, output bit r, output bit d);
        int p, n, steps;
        ev = {}; e = 0; r = 0; d = 0;
        if (w.size() == 0) return;
        n = int'(w[0]);
        if (n == 0 || n > 10) begin e = 1; return; end
        if (w.size() < 2) return;
        if (w[1] != 16'hFFFF) begin e = 1; return; end
        p = 2;
        for (int k = 0; k < n; k++) begin
            if (p + 2 >= w.size()) return;
            if (w[p+2] >= 16'd512) begin e = 1; return; end
            ev.push_back({4'd1, 12'(w[p+2]), w[p], w[p+1]});
            p += 3;
            for (int j = 0; j < n; j++) begin
                if (p >= w.size()) return;
                ev.push_back({4'd2, 12'(j), w[p], 16'h0});
                p++;
            end
        end
        r = 1;
        for (steps = 0; steps < 166 && p < w.size(); steps++) begin
            ev.push_back({4'd3, 12'h0, w[p], 16'h0});
            p++;
        end
        if (steps == 166) begin r = 0; d = 1; end
    endtask

    task automatic send(input logic [15:0] w, input int gap);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        bus.ins = w;
        bus.ins_valid = 1'b1;
        @(posedge clk);
        #1 bus.ins_valid = 1'b0;
    endtask

    task automatic play(input logic [15:0] w[$], input int gap);
        got = {};
        foreach (w[i]) send(w[i], gap);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_l = 1'b0;
        bus.ins_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_l = 1'b1;
        got = {};
    endtask

    function automatic void load_words(output logic [15:0] w[$]);
        w = '{16'h0002, 16'hFFFF, 16'h4400, 16'h4300, 16'h0000, 16'h0001, 16'h0002,
              16'h4500, 16'h4540, 16'h0005, 16'h0000, 16'h0003};
    endfunction

    task automatic test_reset();
        reset_l = 1'b0;
        bus.ins_valid = 1'b0;
        bus.ins = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.ins_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", bus.ins_ready); end
        n_cmp++;
        if ({bus.cfg_wr_en, bus.q_wr_en, bus.mu_bcast_valid, bus.run, bus.done, bus.err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags got %b want 000000", {bus.cfg_wr_en, bus.q_wr_en, bus.mu_bcast_valid, bus.run, bus.done, bus.err});
        end
        n_cmp++;
        if ({bus.cfg_id, bus.cfg_vmem, bus.cfg_mu, bus.q_addr, bus.q_data, bus.mu_bcast_data} !== '0) begin
            n_bad++; $display("FAIL reset_data got %h want 0", {bus.cfg_id, bus.cfg_vmem, bus.cfg_mu, bus.q_addr, bus.q_data, bus.mu_bcast_data});
        end
        reset_l = 1'b1;
        @(posedge clk);
        #1 got = {};
    endtask

    task automatic test_load(input int gap, input string tag);
        logic [15:0] w[$];
        logic [63:0] exp[$];
        bit e, r, d;
        do_reset();
        load_words(w);
        for (int i = 0; i < w.size() - 1; i++) send(w[i], gap);
        n_cmp++;
        if (bus.run !== 1'b0) begin n_bad++; $display("FAIL %s run_early got %b want 0", tag, bus.run); end
        send(w[w.size()-1], gap);
        n_cmp++;
        if (bus.run !== 1'b1) begin n_bad++; $display("FAIL %s run_latency got %b want 1", tag, bus.run); end
        repeat (2) @(posedge clk);
        #1;
        model(w, exp, e, r, d);
        n_cmp++;
        if (got.size() !== exp.size()) begin n_bad++; $display("FAIL %s count got %0d want %0d", tag, got.size(), exp.size()); end
        foreach (exp[i]) if (i < got.size()) begin
            n_cmp++;
            if (got[i] !== exp[i]) begin n_bad++; $display("FAIL %s event%0d got %h want %h", tag, i, got[i], exp[i]); end
        end
        n_cmp++;
        if ({bus.err, bus.run, bus.done} !== {e, r, d}) begin n_bad++; $display("FAIL %s flags got %b want %b", tag, {bus.err, bus.run, bus.done}, {e, r, d}); end
    endtask

    task automatic test_bad_sync();
        logic [15:0] w[$];
        do_reset();
        send(16'h0003, 0);
        send(16'hFFFE, 0);
        n_cmp++;
        if ({bus.err, bus.ins_ready} !== 2'b10) begin n_bad++; $display("FAIL bad_sync err_ready got %b want 10", {bus.err, bus.ins_ready}); end
        load_words(w);
        foreach (w[i]) send(w[i], 0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (got.size() !== 0) begin n_bad++; $display("FAIL bad_sync writes got %0d want 0", got.size()); end
        n_cmp++;
        if ({bus.err, bus.run} !== 2'b10) begin n_bad++; $display("FAIL bad_sync held got %b want 10", {bus.err, bus.run}); end
    endtask

    task automatic test_bounds();
        logic [15:0] w[$];
        logic [63:0] exp[$];
        bit e, r, d;
        do_reset();
        w = '{16'h000B};
        play(w, 0);
        model(w, exp, e, r, d);
        n_cmp++;
        if ({bus.err, bus.ins_ready} !== {e, 1'b0}) begin n_bad++; $display("FAIL bounds_n got %b want %b", {bus.err, bus.ins_ready}, {e, 1'b0}); end
        do_reset();
        w = '{16'h0001, 16'hFFFF, 16'h1111, 16'h2222, 16'h0200, 16'h0005};
        play(w, 1);
        model(w, exp, e, r, d);
        n_cmp++;
        if (bus.err !== e) begin n_bad++; $display("FAIL bounds_id err got %b want %b", bus.err, e); end
        n_cmp++;
        if (got.size() !== exp.size()) begin n_bad++; $display("FAIL bounds_id writes got %0d want %0d", got.size(), exp.size()); end
    endtask

    task automatic test_anneal(input bit rnd, input string tag);
        logic [15:0] w[$];
        logic [63:0] exp[$];
        bit e, r, d;
        int n, sz;
        do_reset();
        if (rnd) begin
            n = $urandom_range(1, 10);
            w = '{16'(n), 16'hFFFF};
            for (int k = 0; k < n; k++) begin
                w.push_back(16'($urandom));
                w.push_back(16'($urandom));
                w.push_back(16'($urandom_range(0, 511)));
                for (int j = 0; j < n; j++) w.push_back(16'($urandom));
            end
            for (int i = 0; i < 166; i++) w.push_back(16'($urandom));
        end else begin
            load_words(w);
            for (int i = 0; i < 166; i++) w.push_back(16'h3C00 + 16'(i));
        end
        play(w, rnd ? $urandom_range(0, 2) : 6);
        model(w, exp, e, r, d);
        n_cmp++;
        if (got.size() !== exp.size()) begin n_bad++; $display("FAIL %s count got %0d want %0d", tag, got.size(), exp.size()); end
        foreach (exp[i]) if (i < got.size()) begin
            n_cmp++;
            if (got[i] !== exp[i]) begin n_bad++; $display("FAIL %s event%0d got %h want %h", tag, i, got[i], exp[i]); end
        end
        n_cmp++;
        if ({bus.err, bus.run, bus.done, bus.ins_ready} !== {e, r, d, 1'b0}) begin
            n_bad++; $display("FAIL %s end_flags got %b want %b", tag, {bus.err, bus.run, bus.done, bus.ins_ready}, {e, r, d, 1'b0});
        end
        sz = got.size();
        send(16'h3C00 + 16'd166, 0);
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (got.size() !== sz) begin n_bad++; $display("FAIL %s extra_word got %0d want %0d", tag, got.size(), sz); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] w[$];
        load_words(w);
        do_reset();
        for (int i = 0; i < 6; i++) send(w[i], 0);
        reset_l = 1'b0;
        bus.ins = 16'h0009;
        bus.ins_valid = 1'b1;
        @(posedge clk);
        #1 got = {};
        repeat (2) @(posedge clk);
        #1;
        bus.ins_valid = 1'b0;
        reset_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (got.size() !== 0) begin n_bad++; $display("FAIL mid_reset pulses got %0d want 0", got.size()); end
        n_cmp++;
        if ({bus.err, bus.run, bus.ins_ready} !== 3'b001) begin n_bad++; $display("FAIL mid_reset state got %b want 001", {bus.err, bus.run, bus.ins_ready}); end
        test_load(0, "after_reset");
    endtask

    initial begin
        bus.ins = '0;
        bus.ins_valid = 1'b0;
        test_reset();
        test_load(0, "load");
        test_bad_sync();
        test_bounds();
        test_load(3, "gapped");
        test_anneal(1'b0, "anneal");
        test_reset();
        test_mid_reset();
        for (int t = 0; t < 3; t++) test_anneal(1'b1, "random");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
